// File: rtl/cmd_proc_if.sv
// cmd_proc_if -- command/response bus between the UART command wrapper, the
// motion/calibration engines and cmd_proc.
//   slave  : view taken by cmd_proc (consumes commands, issues start pulses)
//   master : view taken by the surrounding system / testbench
interface cmd_proc_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tx_done;
    logic        strt_cal;
    logic        cal_done;
    logic        strt_hdng;
    logic [11:0] dsrd_hdg;
    logic        strt_mv;
    logic        stp_lft;
    logic        stp_rght;
    logic        mv_cmplt;
    logic        strt_sol;
    logic        sol_cmplt;

    modport slave (
        input  cmd, cmd_rdy, tx_done, cal_done, mv_cmplt, sol_cmplt,
        output clr_cmd_rdy, send_resp, resp, strt_cal, strt_hdng, dsrd_hdg,
               strt_mv, stp_lft, stp_rght, strt_sol
    );

    modport master (
        output cmd, cmd_rdy, tx_done, cal_done, mv_cmplt, sol_cmplt,
        input  clr_cmd_rdy, send_resp, resp, strt_cal, strt_hdng, dsrd_hdg,
               strt_mv, stp_lft, stp_rght, strt_sol
    );
endinterface

// File: rtl/cmd_proc.sv
// cmd_proc -- decodes 16-bit commands, launches calibrate / heading / move /
// solve operations, waits for the matching completion and returns a one-byte
// response (ACK on completion, NAK for an unknown opcode).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cmd_proc_if.slave (command in, start pulses / response out)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for cmd_rdy; accepts a command combinationally
// STRT      | one-cycle start pulse for the registered opcode
// WAIT_CAL  | waiting for cal_done
// WAIT_MV   | waiting for mv_cmplt (heading or move)
// WAIT_SOL  | waiting for sol_cmplt
// RESP_WAIT | response issued; waiting for tx_done before next command
module cmd_proc #(
    parameter logic [7:0] ACK = 8'hA5,
    parameter logic [7:0] NAK = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    cmd_proc_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, STRT, WAIT_CAL, WAIT_MV, WAIT_SOL, RESP_WAIT
    } state_t;

    state_t      state, nxt_state;
    logic [1:0]  op;          // only valid opcodes reach STRT, so bit 15 is not kept
    logic        send_q;
    logic [7:0]  resp_q;
    logic [11:0] hdg_q;
    logic        lft_q, rght_q;
    logic        accept;
    logic        invalid;
    logic        cmplt;

    // Gated with rst_n so clr_cmd_rdy stays low while reset is held.
    assign accept  = (state == IDLE) && bus.cmd_rdy && rst_n;
    assign invalid = bus.cmd[15];

    always_comb begin
        cmplt = 1'b0;
        case (state)
            WAIT_CAL: cmplt = bus.cal_done;
            WAIT_MV:  cmplt = bus.mv_cmplt;
            WAIT_SOL: cmplt = bus.sol_cmplt;
            default:  cmplt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE: begin
                if (accept) nxt_state = invalid ? RESP_WAIT : STRT;
            end
            STRT: begin
                case (op)
                    2'b00:   nxt_state = WAIT_CAL;
                    2'b11:   nxt_state = WAIT_SOL;
                    default: nxt_state = WAIT_MV;
                endcase
            end
            WAIT_CAL, WAIT_MV, WAIT_SOL: begin
                if (cmplt) nxt_state = RESP_WAIT;
            end
            RESP_WAIT: begin
                // tx_done during the send_resp cycle belongs to the previous byte
                if (bus.tx_done && !send_q) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op     <= 2'b00;
            send_q <= 1'b0;
            resp_q <= 8'h00;
            hdg_q  <= 12'h000;
            lft_q  <= 1'b0;
            rght_q <= 1'b0;
        end else begin
            send_q <= (accept && invalid) || cmplt;
            if (accept) op <= bus.cmd[14:13];
            if (accept && invalid) resp_q <= NAK;
            else if (cmplt)        resp_q <= ACK;
            if (accept && bus.cmd[15:13] == 3'b001) hdg_q <= bus.cmd[11:0];
            if (accept && bus.cmd[15:13] == 3'b010) begin
                lft_q  <= bus.cmd[1];
                rght_q <= bus.cmd[0];
            end
        end
    end

    always_comb begin
        bus.clr_cmd_rdy = accept;
        bus.strt_cal    = (state == STRT) && (op == 2'b00);
        bus.strt_hdng   = (state == STRT) && (op == 2'b01);
        bus.strt_mv     = (state == STRT) && (op == 2'b10);
        bus.strt_sol    = (state == STRT) && (op == 2'b11);
        bus.send_resp   = send_q;
        bus.resp        = resp_q;
        bus.dsrd_hdg    = hdg_q;
        bus.stp_lft     = lft_q;
        bus.stp_rght    = rght_q;
    end

endmodule

// File: tb/tb_cmd_proc.sv
// tb_cmd_proc -- randomized and directed checks of cmd_proc against a
// command-level reference model (opcode -> expected pulse, latched operands,
// expected response byte).
module tb_cmd_proc;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cmd_proc_if bus ();

    cmd_proc #(.ACK(8'hA5), .NAK(8'h5A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed pulses: {strt_cal, strt_hdng, strt_mv, strt_sol, send_resp}
    logic [4:0] obs;
    assign obs = {bus.strt_cal, bus.strt_hdng, bus.strt_mv, bus.strt_sol, bus.send_resp};

    // reference model state
    logic [11:0] m_hdg;
    logic        m_lft, m_rght;
    logic [7:0]  m_resp;

    function automatic logic [4:0] exp_pulse(input logic [2:0] op);
        case (op)
            3'd0:    return 5'b10000;
            3'd1:    return 5'b01000;
            3'd2:    return 5'b00100;
            3'd3:    return 5'b00010;
            default: return 5'b00001;
        endcase
    endfunction

    // completion inputs as {cal_done, mv_cmplt, sol_cmplt}
    function automatic logic [2:0] match_mask(input logic [2:0] op);
        case (op)
            3'd0:    return 3'b100;
            3'd3:    return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    task automatic set_cmp(input logic [2:0] v);
        bus.cal_done  = v[2];
        bus.mv_cmplt  = v[1];
        bus.sol_cmplt = v[0];
    endtask

    task automatic model_reset();
        m_hdg  = 12'h000;
        m_lft  = 1'b0;
        m_rght = 1'b0;
        m_resp = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd = 16'h2123;
        bus.cmd_rdy = 1'b1;
        bus.tx_done = 1'b0;
        set_cmp(3'b111);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({obs, bus.clr_cmd_rdy, bus.resp, bus.dsrd_hdg, bus.stp_lft, bus.stp_rght} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: pulses=%b clr=%b resp=%h hdg=%h lft=%b rght=%b, required all zero",
                     obs, bus.clr_cmd_rdy, bus.resp, bus.dsrd_hdg, bus.stp_lft, bus.stp_rght);
        end
        @(negedge clk);
        bus.cmd_rdy = 1'b0;
        set_cmp(3'b000);
        rst_n = 1'b1;
    endtask

    task automatic test_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.cmd_rdy = 1'b0;
            bus.cmd = 16'($urandom);
            bus.tx_done = 1'($urandom);
            set_cmp(3'($urandom));
            #1;
            total++;
            if ({obs, bus.clr_cmd_rdy} !== 6'd0) begin
                bad++;
                $display("FAIL idle: pulses=%b clr=%b, required 0", obs, bus.clr_cmd_rdy);
            end
        end
    endtask

    // One complete command transaction. The first cycle is the accept cycle.
    // cdly: cycles of waiting before the matching completion; tdly: cycles
    // after send_resp before tx_done; pre_rdy/nxt: next command presented
    // while busy; noisy: all completion inputs high in the start cycle.
    task automatic test_command(input logic [15:0] c, input int cdly, input int tdly,
                                input bit pre_rdy, input logic [15:0] nxt, input bit noisy);
        logic [2:0] op;
        logic [2:0] mm;
        op = c[15:13];
        mm = match_mask(op);

        // cycle N
        @(negedge clk);
        bus.cmd = c;
        bus.cmd_rdy = 1'b1;
        bus.tx_done = 1'($urandom);
        set_cmp(3'($urandom));
        #1;
        total++;
        if (bus.clr_cmd_rdy !== 1'b1 || obs !== 5'd0) begin
            bad++;
            $display("FAIL accept: clr=%b pulses=%b, required clr=1 pulses=00000", bus.clr_cmd_rdy, obs);
        end
        total++;
        if ({bus.dsrd_hdg, bus.stp_lft, bus.stp_rght, bus.resp} !== {m_hdg, m_lft, m_rght, m_resp}) begin
            bad++;
            $display("FAIL hold_before_load: hdg=%h lft=%b rght=%b resp=%h, required %h %b %b %h",
                     bus.dsrd_hdg, bus.stp_lft, bus.stp_rght, bus.resp, m_hdg, m_lft, m_rght, m_resp);
        end
        if (op == 3'd1) m_hdg = c[11:0];
        if (op == 3'd2) {m_lft, m_rght} = c[1:0];
        if (op >= 3'd4) m_resp = 8'h5A;

        // cycle N+1
        @(negedge clk);
        bus.cmd = nxt;
        bus.cmd_rdy = pre_rdy;
        bus.tx_done = 1'($urandom);
        set_cmp(noisy ? 3'b111 : 3'($urandom));
        #1;
        total++;
        if (obs !== exp_pulse(op) || bus.clr_cmd_rdy !== 1'b0) begin
            bad++;
            $display("FAIL start_pulse op=%0d: pulses=%b clr=%b, required %b clr=0", op, obs, bus.clr_cmd_rdy, exp_pulse(op));
        end
        total++;
        if ({bus.dsrd_hdg, bus.stp_lft, bus.stp_rght, bus.resp} !== {m_hdg, m_lft, m_rght, m_resp}) begin
            bad++;
            $display("FAIL operands: hdg=%h lft=%b rght=%b resp=%h, required %h %b %b %h",
                     bus.dsrd_hdg, bus.stp_lft, bus.stp_rght, bus.resp, m_hdg, m_lft, m_rght, m_resp);
        end

        if (op < 3'd4) begin
            for (int i = 0; i < cdly; i++) begin
                @(negedge clk);
                bus.tx_done = 1'($urandom);
                set_cmp(3'($urandom) & ~mm);
                #1;
                total++;
                if ({obs, bus.clr_cmd_rdy} !== 6'd0) begin
                    bad++;
                    $display("FAIL wait_quiet op=%0d: pulses=%b clr=%b, required 0", op, obs, bus.clr_cmd_rdy);
                end
            end
            // cycle M
            @(negedge clk);
            set_cmp(3'($urandom) | mm);
            #1;
            total++;
            if ({obs, bus.clr_cmd_rdy} !== 6'd0) begin
                bad++;
                $display("FAIL cmplt_cycle: pulses=%b clr=%b, required 0", obs, bus.clr_cmd_rdy);
            end
            m_resp = 8'hA5;
            // cycle M+1
            @(negedge clk);
            set_cmp(3'($urandom));
            bus.tx_done = 1'($urandom);
            #1;
            total++;
            if (obs !== 5'b00001 || bus.resp !== m_resp || bus.clr_cmd_rdy !== 1'b0) begin
                bad++;
                $display("FAIL ack: pulses=%b resp=%h clr=%b, required 00001 resp=%h clr=0", obs, bus.resp, bus.clr_cmd_rdy, m_resp);
            end
        end

        for (int i = 0; i < tdly; i++) begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            set_cmp(3'($urandom));
            #1;
            total++;
            if ({obs, bus.clr_cmd_rdy} !== 6'd0 || bus.resp !== m_resp) begin
                bad++;
                $display("FAIL resp_wait: pulses=%b clr=%b resp=%h, required 0 0 %h", obs, bus.clr_cmd_rdy, bus.resp, m_resp);
            end
        end
        // cycle T
        @(negedge clk);
        bus.tx_done = 1'b1;
        set_cmp(3'($urandom));
        #1;
        total++;
        if ({obs, bus.clr_cmd_rdy} !== 6'd0 || bus.resp !== m_resp) begin
            bad++;
            $display("FAIL tx_done_cycle: pulses=%b clr=%b resp=%h, required 0 0 %h", obs, bus.clr_cmd_rdy, bus.resp, m_resp);
        end
    endtask

    task automatic test_reset_mid_move();
        test_command(16'h4003, 0, 0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        bus.cmd = 16'h2ABC;
        bus.cmd_rdy = 1'b1;
        set_cmp(3'b000);
        #1;
        m_hdg = 12'hABC;
        @(negedge clk);
        bus.cmd_rdy = 1'b0;
        #1;
        total++;
        if (obs !== 5'b01000 || bus.dsrd_hdg !== 12'hABC) begin
            bad++;
            $display("FAIL mid_reset_setup: pulses=%b hdg=%h, required 01000 abc", obs, bus.dsrd_hdg);
        end
        @(negedge clk);
        bus.cmd_rdy = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({obs, bus.clr_cmd_rdy, bus.resp, bus.dsrd_hdg, bus.stp_lft, bus.stp_rght} !== 27'd0) begin
            bad++;
            $display("FAIL mid_reset: pulses=%b clr=%b resp=%h hdg=%h lft=%b rght=%b, required all zero",
                     obs, bus.clr_cmd_rdy, bus.resp, bus.dsrd_hdg, bus.stp_lft, bus.stp_rght);
        end
        @(negedge clk);
        bus.cmd_rdy = 1'b0;
        rst_n = 1'b1;
        set_cmp(3'b010);
        @(negedge clk);
        set_cmp(3'b000);
        #1;
        total++;
        if (obs !== 5'd0) begin
            bad++;
            $display("FAIL post_reset_cmplt: pulses=%b, required 00000", obs);
        end
    endtask

    task automatic test_back_to_back();
        test_command(16'h6000, 3, 4, 1'b1, 16'h23FF, 1'b0);
        test_command(16'h23FF, 2, 1, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_random(input int n);
        logic [15:0] cur, nx;
        bit          hold;
        cur = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            nx = 16'($urandom);
            hold = 1'($urandom);
            test_command(cur, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), hold, nx, 1'($urandom));
            if (!hold) test_idle(int'($urandom_range(0, 2)));
            cur = nx;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_command(16'h23FF, 2, 1, 1'b0, 16'h0000, 1'b0);   // heading
        test_command(16'h4002, 1, 0, 1'b0, 16'h0000, 1'b1);   // move, mv_cmplt in strt cycle
        test_command(16'h0000, 4, 2, 1'b0, 16'h0000, 1'b1);   // calibrate
        test_command(16'hE000, 0, 2, 1'b0, 16'h0000, 1'b0);   // invalid
        test_idle(3);
        test_back_to_back();
        test_reset_mid_move();
        test_random(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_proc.md
CMD_PROC -- requirements
Module: cmd_proc

Interface
REQ-001 Parameter ACK, default 8'hA5, response byte for a successfully completed command.
REQ-002 Parameter NAK, default 8'h5A, response byte for an unrecognised opcode.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cmd  input  16  command word from the UART command wrapper; valid while cmd_rdy=1.
REQ-006 cmd_rdy  input  1  a complete 16-bit command is waiting.
REQ-007 clr_cmd_rdy  output  1  one-cycle pulse; consumes the pending command.
REQ-008 send_resp  output  1  one-cycle pulse to the UART trmt input.
REQ-009 resp  output  8  response byte; stable from the send_resp cycle until the next send_resp.
REQ-010 tx_done  input  1  UART transmit complete (level).
REQ-011 strt_cal  output  1  one-cycle pulse; start gyro calibration.
REQ-012 cal_done  input  1  calibration finished.
REQ-013 strt_hdng  output  1  one-cycle pulse; start heading change.
REQ-014 dsrd_hdg  output  12  desired heading.
REQ-015 strt_mv  output  1  one-cycle pulse; start maze move.
REQ-016 stp_lft, stp_rght  output  1 each  move-termination options for the move in progress.
REQ-017 mv_cmplt  input  1  heading or move finished.
REQ-018 strt_sol  output  1  one-cycle pulse; start autonomous solve.
REQ-019 sol_cmplt  input  1  solve finished.

Function
REQ-020 Opcode is cmd[15:13]:
  - 000 = calibrate
  - 001 = heading
  - 010 = move
  - 011 = solve
  - 100-111 = invalid
REQ-021 FSM states:
  - IDLE
  - STRT: the one-cycle pulse state
  - WAIT_CAL
  - WAIT_MV
  - WAIT_SOL
  - RESP_WAIT
REQ-022 Accepting a command:
  - Condition: in IDLE with cmd_rdy=1 in cycle N.
  - clr_cmd_rdy=1 combinationally in cycle N.
  - The opcode and its operand fields are registered at the end of cycle N.
REQ-023 In IDLE with cmd_rdy=0, clr_cmd_rdy shall be 0. In all non-IDLE states, clr_cmd_rdy shall be 0 regardless of cmd_rdy; the pending command stays queued.
REQ-024 Calibrate: strt_cal=1 in cycle N+1 only; the FSM then enters WAIT_CAL.
REQ-025 Heading: dsrd_hdg loads cmd[11:0] at the end of cycle N; strt_hdng=1 in cycle N+1 only; the FSM then enters WAIT_MV.
REQ-026 Move: stp_lft loads cmd[1] and stp_rght loads cmd[0] at the end of cycle N; strt_mv=1 in cycle N+1 only; the FSM then enters WAIT_MV.
REQ-027 Solve: strt_sol=1 in cycle N+1 only; the FSM then enters WAIT_SOL.
REQ-028 dsrd_hdg, stp_lft and stp_rght hold until the next accepted heading or move command, respectively.
REQ-029 Completion inputs are ignored in cycle N+1 (the strt cycle) and in every state other than the matching WAIT state.
REQ-030 Completion detection:
  - WAIT_CAL looks only at cal_done.
  - WAIT_MV looks only at mv_cmplt.
  - WAIT_SOL looks only at sol_cmplt.
REQ-031 When the matching completion input =1 in cycle M: send_resp=1 in cycle M+1 only, resp=ACK from cycle M+1, and the FSM enters RESP_WAIT.
REQ-032 Invalid opcode: no strt_* pulse; send_resp=1 in cycle N+1 with resp=NAK; the FSM enters RESP_WAIT.
REQ-033 RESP_WAIT returns to IDLE on the first cycle, starting with the cycle after send_resp, in which tx_done=1. Until then, no new command is accepted.
REQ-034 At most one strt_* or send_resp pulse per cycle; no two pulses ever overlap.
REQ-035 cmd_rdy held high across the return to IDLE: the next command is accepted in the first IDLE cycle.

Reset
REQ-036 While rst_n=0, and immediately on its assertion (including mid-operation in any state), the block shall be in this state:
  - FSM in IDLE.
  - All pulse outputs =0.
  - clr_cmd_rdy=0.
  - resp=8'h00, dsrd_hdg=12'h000, stp_lft=0, stp_rght=0.
REQ-037 After rst_n deasserts, the first accept may occur in the first clock cycle.

Verification
REQ-038 Heading: cmd=16'h23FF with cmd_rdy=1 -> clr_cmd_rdy=1 same cycle; strt_hdng=1 next cycle with dsrd_hdg=12'h3FF; mv_cmplt pulse -> send_resp next cycle, resp=8'hA5; tx_done -> IDLE.
REQ-039 Move: cmd=16'h4002 -> strt_mv one cycle with stp_lft=1, stp_rght=0; mv_cmplt held high during the strt cycle is ignored, and a later mv_cmplt produces an ACK.
REQ-040 Calibrate: cmd=16'h0000 -> strt_cal; mv_cmplt and sol_cmplt pulses are ignored; cal_done -> resp=8'hA5.
REQ-041 Invalid opcode: cmd=16'hE000 -> no strt_*; send_resp in cycle N+1 with resp=8'h5A.
REQ-042 Back-to-back: second cmd_rdy held high during WAIT_SOL and RESP_WAIT -> clr_cmd_rdy=0 throughout; the second command is accepted in the first IDLE cycle after tx_done.
REQ-043 Reset asserted during WAIT_MV -> all outputs at reset values immediately; a later mv_cmplt produces no send_resp.
